// File: rtl/sattn_pkg.sv
// Shared definitions for the sparse-attention accelerator: register map,
// opcodes and the MMIO sequencer state encoding.
package sattn_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_CFG,
    WR_IADDR,
    WR_IDATA,
    ISSUE,
    POLL,
    SETTLE,
    RD_SUM,
    FIN
  } state_t;

  localparam int NUM_CFG = 6;

  localparam logic [7:0] REG_CFG_BASE = 8'h30;
  localparam logic [7:0] REG_CMD      = 8'h60;
  localparam logic [7:0] REG_SUM0     = 8'h68;
  localparam logic [7:0] REG_IADDR    = 8'h70;
  localparam logic [7:0] REG_IDATA    = 8'h78;
  localparam logic [7:0] REG_SUM1     = 8'h80;
  localparam logic [7:0] REG_SUM2     = 8'h88;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_SUM0 = 8'h14;
  localparam logic [7:0] OP_SUM1 = 8'h15;
  localparam logic [7:0] OP_SUM2 = 8'h16;

  // Config registers sit on consecutive 64-bit slots starting at REG_CFG_BASE.
  function automatic logic [7:0] cfg_addr(input logic [2:0] k);
    return REG_CFG_BASE + {2'b00, k, 3'b000};
  endfunction

  function automatic logic has_sum(input logic [7:0] op);
    return (op == OP_SUM0) || (op == OP_SUM1) || (op == OP_SUM2);
  endfunction

  function automatic logic [7:0] sum_addr(input logic [7:0] op);
    case (op)
      OP_SUM1: return REG_SUM1;
      OP_SUM2: return REG_SUM2;
      default: return REG_SUM0;
    endcase
  endfunction

endpackage

// File: rtl/sattn_mmio_seq_if.sv
// MMIO initiator/responder bus; read data is combinational from the responder.
interface sattn_mmio_seq_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64
);

  logic                  wen;
  logic                  ren;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output wen, output ren, output addr, output wdata, input rdata);
  modport slave  (input wen, input ren, input addr, input wdata, output rdata);

endinterface

// File: rtl/sattn_mmio_seq.sv
// Job sequencer: programs the accelerator over MMIO, streams the index table,
// issues the command, polls for completion and fetches the checksum.
module sattn_mmio_seq
  import sattn_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic [7:0]              cmd_op,
  input  logic [31:0]             m_rows,
  input  logic [31:0]             head_dim_d,
  input  logic [31:0]             block_size,
  input  logic [31:0]             k_blocks,
  input  logic [31:0]             s_tokens,
  input  logic [31:0]             scale_fp_bits,
  input  logic [15:0]             n_idx,
  input  logic                    idx_valid,
  output logic                    idx_ready,
  input  logic [15:0]             idx_data,
  sattn_mmio_seq_if.master        mmio,
  output logic [63:0]             result_sum,
  output logic [31:0]             result_cycles
);

  state_t                state;
  logic [7:0]            op_q;
  logic [15:0]           n_q;
  logic [15:0]           idx_cnt;
  logic [2:0]            cfg_cnt;
  logic [31:0]           cfg_q [NUM_CFG];
  logic                  wen_q;
  logic                  ren_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  idx_wr;

  // The index-data write must coincide with the stream transfer, so it bypasses
  // the output registers; every other bus cycle is driven from registers.
  assign idx_wr     = (state == WR_IDATA) && idx_valid;
  assign idx_ready  = idx_wr;
  assign busy       = (state != IDLE);
  assign mmio.wen   = wen_q | idx_wr;
  assign mmio.ren   = ren_q;
  assign mmio.addr  = idx_wr ? ADDR_WIDTH'(REG_IDATA) : addr_q;
  assign mmio.wdata = idx_wr ? DATA_WIDTH'(idx_data) : wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      done          <= 1'b0;
      err           <= 1'b0;
      wen_q         <= 1'b0;
      ren_q         <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      result_sum    <= '0;
      result_cycles <= '0;
      op_q          <= '0;
      n_q           <= '0;
      idx_cnt       <= '0;
      cfg_cnt       <= '0;
      for (int k = 0; k < NUM_CFG; k++) cfg_q[k] <= '0;
    end else begin
      done    <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q          <= cmd_op;
            n_q           <= n_idx;
            cfg_q[0]      <= m_rows;
            cfg_q[1]      <= head_dim_d;
            cfg_q[2]      <= block_size;
            cfg_q[3]      <= k_blocks;
            cfg_q[4]      <= s_tokens;
            cfg_q[5]      <= scale_fp_bits;
            result_sum    <= '0;
            result_cycles <= '0;
            err           <= 1'b0;
            idx_cnt       <= '0;
            cfg_cnt       <= '0;
            if (cmd_op == OP_NOP) begin
              state <= FIN;
              err   <= 1'b1;
              done  <= 1'b1;
            end else begin
              state   <= WR_CFG;
              wen_q   <= 1'b1;
              addr_q  <= ADDR_WIDTH'(REG_CFG_BASE);
              wdata_q <= DATA_WIDTH'(m_rows);
            end
          end
        end
        WR_CFG: begin
          if (cfg_cnt != 3'(NUM_CFG - 1)) begin
            cfg_cnt <= cfg_cnt + 3'd1;
            wen_q   <= 1'b1;
            addr_q  <= ADDR_WIDTH'(cfg_addr(cfg_cnt + 3'd1));
            wdata_q <= DATA_WIDTH'(cfg_q[cfg_cnt + 3'd1]);
          end else if (n_q == 16'd0) begin
            state   <= ISSUE;
            wen_q   <= 1'b1;
            addr_q  <= ADDR_WIDTH'(REG_CMD);
            wdata_q <= DATA_WIDTH'(op_q);
          end else begin
            state  <= WR_IADDR;
            wen_q  <= 1'b1;
            addr_q <= ADDR_WIDTH'(REG_IADDR);
          end
        end
        WR_IADDR: state <= WR_IDATA;
        WR_IDATA: begin
          if (idx_valid) begin
            if (idx_cnt == n_q - 16'd1) begin
              state   <= ISSUE;
              wen_q   <= 1'b1;
              addr_q  <= ADDR_WIDTH'(REG_CMD);
              wdata_q <= DATA_WIDTH'(op_q);
            end else begin
              state   <= WR_IADDR;
              idx_cnt <= idx_cnt + 16'd1;
              wen_q   <= 1'b1;
              addr_q  <= ADDR_WIDTH'(REG_IADDR);
              wdata_q <= DATA_WIDTH'(idx_cnt + 16'd1);
            end
          end
        end
        ISSUE: begin
          state  <= POLL;
          ren_q  <= 1'b1;
          addr_q <= ADDR_WIDTH'(REG_CMD);
        end
        // The responder shows done for a single cycle, so it is sampled on every poll cycle.
        POLL: begin
          if (result_cycles < 32'(TIMEOUT)) result_cycles <= result_cycles + 32'd1;
          if (mmio.rdata[0]) begin
            state <= SETTLE;
          end else if (result_cycles >= 32'(TIMEOUT - 1)) begin
            state      <= FIN;
            err        <= 1'b1;
            done       <= 1'b1;
            result_sum <= '0;
          end else begin
            ren_q  <= 1'b1;
            addr_q <= ADDR_WIDTH'(REG_CMD);
          end
        end
        SETTLE: begin
          if (has_sum(op_q)) begin
            state  <= RD_SUM;
            ren_q  <= 1'b1;
            addr_q <= ADDR_WIDTH'(sum_addr(op_q));
          end else begin
            state      <= FIN;
            done       <= 1'b1;
            result_sum <= '0;
          end
        end
        RD_SUM: begin
          result_sum <= 64'(mmio.rdata);
          state      <= FIN;
          done       <= 1'b1;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sattn_mmio_seq.md
SATTN_MMIO_SEQ -- requirements
Module: sattn_mmio_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, MMIO address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, MMIO data width.
REQ-003 SHALL have parameter TIMEOUT, default 65535, maximum number of poll cycles before abort.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous active-high reset; one clock domain only.
REQ-005 SHALL have: start in 1, job request pulse; busy out 1, sequence active; done out 1, one-cycle completion pulse; err out 1, valid with done.
REQ-006 SHALL have: cmd_op in 8, opcode; m_rows, head_dim_d, block_size, k_blocks, s_tokens, scale_fp_bits in 32 each, job descriptor; n_idx in 16, number of index entries.
REQ-007 SHALL have: idx_valid in 1; idx_ready out 1; idx_data in 16; index stream, transfer when both are high.
REQ-008 SHALL have MMIO initiator ports: mmio_wen out 1; mmio_ren out 1; mmio_addr out ADDR_WIDTH; mmio_wdata out DATA_WIDTH; mmio_rdata in DATA_WIDTH, combinational read data from the responder.
REQ-009 SHALL have: result_sum out 64, returned checksum; result_cycles out 32, poll cycles spent.

Function
REQ-010 SHALL latch all descriptor inputs on a start cycle taken in IDLE; start SHALL be ignored while busy.
REQ-011 SHALL use states IDLE, WR_CFG, WR_IADDR, WR_IDATA, ISSUE, POLL, SETTLE, RD_SUM, FIN.
REQ-012 In WR_CFG, SHALL write one register per cycle at offsets 0x30,0x38,0x40,0x48,0x50,0x58 (m_rows, head_dim_d, block_size, k_blocks, s_tokens, scale_fp_bits), each zero-extended to 64 bits.
REQ-013 SHALL drive mmio_wen for exactly one cycle per write; the responder has no backpressure and accepts every write.
REQ-014 For each index i = 0..n_idx-1, SHALL write i to 0x70 (WR_IADDR), then write idx_data to 0x78 (WR_IDATA) in the same cycle as the transfer.
REQ-015 SHALL hold idx_ready high only in WR_IDATA; while idx_valid=0, mmio_wen SHALL stay low and the state SHALL hold.
REQ-016 n_idx=0 SHALL skip directly from WR_CFG to ISSUE.
REQ-017 ISSUE SHALL write cmd_op to 0x60 for one cycle.
REQ-018 POLL SHALL hold mmio_ren=1 and mmio_addr=0x60 on every cycle, sampling mmio_rdata[0] (done) each cycle, because done is visible for a single cycle only.
REQ-019 POLL SHALL increment result_cycles each cycle and saturate at TIMEOUT.
REQ-020 When done is sampled, SHALL spend one SETTLE cycle, because the responder latches its checksum one cycle after done.
REQ-021 RD_SUM SHALL issue a single-cycle read and capture mmio_rdata into result_sum.
REQ-022 The RD_SUM address SHALL be 0x68 for opcode 0x14, 0x80 for 0x15, and 0x88 for 0x16.
REQ-023 For any other non-zero opcode, SHALL skip RD_SUM and set result_sum=0.
REQ-024 If result_cycles reaches TIMEOUT in POLL, SHALL go to FIN with err=1 and result_sum=0.
REQ-025 cmd_op=0x00 SHALL go from IDLE to FIN the next cycle with err=1 and no MMIO traffic.
REQ-026 FIN SHALL pulse done for one cycle and then return to IDLE.
REQ-027 result_sum, result_cycles and err SHALL hold until the next accepted start.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 mmio_wdata and mmio_addr SHALL be 0 when neither mmio_wen nor mmio_ren is high.
REQ-030 mmio_wen and mmio_ren SHALL never be high in the same cycle.

Reset
REQ-031 rst SHALL force IDLE and zero all outputs (busy, done, err, idx_ready, mmio_*, result_*) at the next clk edge.
REQ-032 rst mid-sequence SHALL abort without completing partial writes.
REQ-033 The responder state is not restored by rst; the next start SHALL reprogram all registers.

Structure
REQ-034 The register offsets, opcode values and state enum SHALL live in shared package sattn_pkg, also used by the accelerator register file.
REQ-035 A single FSM with an index counter and a poll counter is sufficient; no sub-module is required.

Verification
REQ-036 Opcode 0x14, n_idx=2, idx {3,7}; responder done at poll cycle 10; 0x68=0xDEAD -> writes in order 0x30..0x58, 0x70=0, 0x78=3, 0x70=1, 0x78=7, 0x60=0x14; SETTLE; read 0x68; result_sum=0xDEAD, result_cycles=10, err=0.
REQ-037 idx_valid low for 5 cycles before the second index -> no mmio_wen during the stall; idx_ready high only in the transfer cycle.
REQ-038 Opcode 0x15, done=1 for exactly one cycle -> captured; read at 0x80; done pulse width is 1.
REQ-039 TIMEOUT=32, responder never done -> err=1, result_sum=0, result_cycles=32, done pulse.
REQ-040 cmd_op=0x00 -> done and err the cycle after start; zero MMIO activity.
REQ-041 rst asserted during WR_IDATA, then a new start with opcode 0x16 -> all outputs 0 after reset; the full sequence restarts at 0x30 and reads 0x88.
